timing_loop_nco: RTL and testbench

//  Symbol-timing loop filter + NCO for the MSK receiver. It closes the timing-recovery loop

---
 rtl/timing_loop_nco.sv | 124 ++++++++++++
 tb/tb_timing_loop_nco.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/timing_loop_nco.sv
// Symbol-timing PI loop filter and NCO for the MSK receiver: turns the Gardner
// TED error into a symbol strobe plus fractional interval for the interpolator.
module timing_loop_nco #(
  parameter int     OSF      = 20,
  parameter int     WERR     = 18,
  parameter int     WCTRL    = 24,
  parameter int     WACC     = 32,
  parameter int     WMU      = 16,
  parameter longint NOM_STEP = 64'sd214748365,
  parameter int     KP_SHIFT = 6,
  parameter int     KI_SHIFT = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             iq_val,
  input  logic [WERR-1:0]  e_in,
  input  logic             e_valid,
  input  logic             loop_en,
  output logic             sym_valid_o,
  output logic [WMU-1:0]   mu_o,
  output logic [WCTRL-1:0] ctrl_o,
  output logic [WCTRL-1:0] integ_o
);

  localparam int WF = WCTRL + 2;
  localparam logic signed [WF-1:0] SAT_HI = WF'((64'sd1 <<< (WCTRL - 1)) - 64'sd1);
  localparam logic signed [WF-1:0] SAT_LO = -SAT_HI;
  localparam logic [WACC:0]        NOM_W  = (WACC + 1)'(NOM_STEP);
  localparam logic [WACC-1:0]      OSF_W  = WACC'(OSF);

  // The step must stay well inside (NOM/2, 3*NOM/2) so one sample never wraps twice.
  if ((64'sd1 <<< (WCTRL - 1)) >= (NOM_STEP / 64'sd2)) begin : g_width_check
    $error("timing_loop_nco: 2^(WCTRL-1) must be below NOM_STEP/2");
  end

  // Symmetric clamp: the negative limit mirrors the positive one so the loop has no bias.
  function automatic logic [WCTRL-1:0] sat(input logic signed [WF-1:0] x);
    logic [WCTRL-1:0] y;
    if (x > SAT_HI) begin
      y = WCTRL'(SAT_HI);
    end else if (x < SAT_LO) begin
      y = WCTRL'(SAT_LO);
    end else begin
      y = WCTRL'(x);
    end
    return y;
  endfunction

  logic [WACC-1:0]       phase_r;
  logic [WCTRL-1:0]      integ_r;
  logic [WCTRL-1:0]      ctrl_r;
  logic                  sym_valid_r;
  logic [WMU-1:0]        mu_r;

  logic signed [WF-1:0]  e_ext_s;
  logic signed [WF-1:0]  prop_s;
  logic signed [WF-1:0]  inc_s;
  logic signed [WF-1:0]  integ_ext_s;
  logic signed [WF-1:0]  integ_n_ext_s;
  logic [WCTRL-1:0]      integ_n_s;
  logic [WCTRL-1:0]      ctrl_n_s;
  logic [WACC:0]         step_s;
  logic [WACC:0]         sum_s;
  logic [WMU-1:0]        mu_n_s;

  // PI filter next state: integrator saturates first, then prop + integrator saturates again.
  always_comb begin
    e_ext_s       = {{(WF - WERR){e_in[WERR-1]}}, e_in};
    prop_s        = e_ext_s >>> KP_SHIFT;
    inc_s         = e_ext_s >>> KI_SHIFT;
    integ_ext_s   = {{(WF - WCTRL){integ_r[WCTRL-1]}}, integ_r};
    integ_n_s     = sat(integ_ext_s + inc_s);
    integ_n_ext_s = {{(WF - WCTRL){integ_n_s[WCTRL-1]}}, integ_n_s};
    ctrl_n_s      = sat(prop_s + integ_n_ext_s);
  end

  // NCO next state from the registered control word; carry out of WACC is the symbol wrap.
  always_comb begin
    step_s = NOM_W + {{(WACC + 1 - WCTRL){ctrl_r[WCTRL-1]}}, ctrl_r};
    sum_s  = {1'b0, phase_r} + step_s;
    mu_n_s = WMU'((sum_s[WACC-1:0] * OSF_W) >> (WACC - WMU));
  end

  // State registers: loop_en low parks the filter at zero without touching the phase.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_r     <= {WACC{1'b0}};
      integ_r     <= {WCTRL{1'b0}};
      ctrl_r      <= {WCTRL{1'b0}};
      sym_valid_r <= 1'b0;
      mu_r        <= {WMU{1'b0}};
    end else begin
      if (!loop_en) begin
        integ_r <= {WCTRL{1'b0}};
        ctrl_r  <= {WCTRL{1'b0}};
      end else if (e_valid) begin
        integ_r <= integ_n_s;
        ctrl_r  <= ctrl_n_s;
      end else begin
        integ_r <= integ_r;
        ctrl_r  <= ctrl_r;
      end
      if (iq_val) begin
        phase_r     <= sum_s[WACC-1:0];
        sym_valid_r <= sum_s[WACC];
        if (sum_s[WACC]) begin
          mu_r <= mu_n_s;
        end else begin
          mu_r <= mu_r;
        end
      end else begin
        phase_r     <= phase_r;
        sym_valid_r <= 1'b0;
        mu_r        <= mu_r;
      end
    end
  end

  assign sym_valid_o = sym_valid_r;
  assign mu_o        = mu_r;
  assign ctrl_o      = ctrl_r;
  assign integ_o     = integ_r;

endmodule

// File: tb/tb_timing_loop_nco.sv
// Scoreboard bench for timing_loop_nco: a default instance and a KI_SHIFT=0
// instance share stimulus; a behavioural model predicts every output each cycle.
module tb_timing_loop_nco;

  logic        clk = 1'b0;
  logic        reset_n, iq_val, e_valid, loop_en;
  logic [17:0] e_in;
  logic        sv0, sv1;
  logic [15:0] mu0, mu1;
  logic signed [23:0] ctrl0, integ0, ctrl1, integ1;

  always #5 clk = ~clk;

  timing_loop_nco dut (
    .clk(clk), .reset_n(reset_n), .iq_val(iq_val), .e_in(e_in), .e_valid(e_valid),
    .loop_en(loop_en), .sym_valid_o(sv0), .mu_o(mu0), .ctrl_o(ctrl0), .integ_o(integ0));

  timing_loop_nco #(.KI_SHIFT(0)) dut_sat (
    .clk(clk), .reset_n(reset_n), .iq_val(iq_val), .e_in(e_in), .e_valid(e_valid),
    .loop_en(loop_en), .sym_valid_o(sv1), .mu_o(mu1), .ctrl_o(ctrl1), .integ_o(integ1));

  localparam longint NOM   = 64'sd214748365;
  localparam longint TWO32 = 64'sd4294967296;
  localparam longint LIM   = 64'sd8388607;

  typedef struct {
    bit     sv;
    longint mu;
    longint ctrl;
    longint integ;
  } exp_t;

  exp_t   sb0[$];
  exp_t   sb1[$];
  longint m_phase[2], m_ctrl[2], m_integ[2], m_mu[2];
  bit     m_sv[2];
  int     ki_sh[2] = '{12, 0};

  int n_vec = 0;
  int n_err = 0;
  int cnt[2], ivl[2], nstrb[2], mn[2], mx[2], lo[2], hi[2];
  bit per_on[2], per_arm[2];

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint clamp(input longint x);
    return (x > LIM) ? LIM : ((x < -LIM) ? -LIM : x);
  endfunction

  task automatic model_step(input int d, input bit r, input bit iq, input bit ev,
                            input bit en, input longint e);
    longint s;
    exp_t ex;
    if (!r) begin
      m_phase[d] = 0; m_ctrl[d] = 0; m_integ[d] = 0; m_mu[d] = 0; m_sv[d] = 0;
    end else begin
      m_sv[d] = 0;
      if (iq) begin
        s = m_phase[d] + NOM + m_ctrl[d];
        if (s >= TWO32) begin
          s = s - TWO32;
          m_sv[d] = 1;
          m_mu[d] = ((s * 20) / 65536) % 65536;
        end
        m_phase[d] = s;
      end
      if (!en) begin
        m_integ[d] = 0;
        m_ctrl[d]  = 0;
      end else if (ev) begin
        m_integ[d] = clamp(m_integ[d] + fdiv(e, 64'sd1 <<< ki_sh[d]));
        m_ctrl[d]  = clamp(fdiv(e, 64'sd64) + m_integ[d]);
      end
    end
    ex = '{m_sv[d], m_mu[d], m_ctrl[d], m_integ[d]};
    if (d == 0) sb0.push_back(ex);
    else        sb1.push_back(ex);
  endtask

  task automatic set_win(input int d, input bit on, input int l, input int h);
    per_on[d] = on; per_arm[d] = 0; lo[d] = l; hi[d] = h; mn[d] = 9999; mx[d] = 0;
  endtask

  task automatic cmp(input int d, input exp_t ex, input longint sv, input longint mu,
                     input longint ctrl, input longint integ, input bit r, input bit iq);
    check($sformatf("d%0d.sym_valid", d), sv, ex.sv);
    check($sformatf("d%0d.mu", d), mu, ex.mu);
    check($sformatf("d%0d.ctrl", d), ctrl, ex.ctrl);
    check($sformatf("d%0d.integ", d), integ, ex.integ);
    if (!r) begin
      cnt[d] = 0; nstrb[d] = 0; per_on[d] = 0;
    end else begin
      if (iq) cnt[d]++;
      if (sv != 0) begin
        ivl[d] = cnt[d];
        cnt[d] = 0;
        nstrb[d]++;
        if (per_on[d]) begin
          if (per_arm[d]) begin
            check($sformatf("d%0d.period", d), ivl[d],
                  (ivl[d] < lo[d]) ? lo[d] : ((ivl[d] > hi[d]) ? hi[d] : ivl[d]));
            if (ivl[d] < mn[d]) mn[d] = ivl[d];
            if (ivl[d] > mx[d]) mx[d] = ivl[d];
          end
          per_arm[d] = 1;
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit iq, input bit ev, input bit en, input longint e);
    exp_t ex0, ex1;
    reset_n = r; iq_val = iq; e_valid = ev; loop_en = en; e_in = 18'(e);
    model_step(0, r, iq, ev, en, e);
    model_step(1, r, iq, ev, en, e);
    @(posedge clk);
    #1;
    ex0 = sb0.pop_front();
    ex1 = sb1.pop_front();
    cmp(0, ex0, sv0, mu0, ctrl0, integ0, r, iq);
    cmp(1, ex1, sv1, mu1, ctrl1, integ1, r, iq);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; iq_val = 1'b0; e_valid = 1'b0; loop_en = 1'b0; e_in = 18'd0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 4096);
    check("rst.sym_valid", sv0, 0);
    check("rst.ctrl", ctrl0, 0);
    check("rst.integ", integ0, 0);

    // Free-run from reset: first strobe after sample 20, then every 20 samples, mu=0
    for (int i = 0; i < 100; i++) begin
      cyc(1, 1, 0, 0, 0);
      if (sv0) begin
        check(nstrb[0] == 1 ? "free.first" : "free.period", ivl[0], 20);
        check("free.mu", mu0, 0);
      end
    end
    check("free.count", nstrb[0], 5);

    // PI update with +4096, some pulses coinciding with samples
    for (int i = 0; i < 100; i++) begin
      cyc(1, i % 2, 1, 1, 4096);
      if (i == 0) check("pi.latency", ctrl0, 65);
      cyc(1, 1, 0, 1, 0);
    end
    check("pi.integ", integ0, 100);
    check("pi.ctrl", ctrl0, 164);
    cyc(1, 1, 0, 0, 0);
    check("pi.drop_integ", integ0, 0);
    check("pi.drop_ctrl", ctrl0, 0);
    cyc(1, 0, 1, 1, -4096);
    check("pi.neg_integ", integ0, -1);
    check("pi.neg_ctrl", ctrl0, -65);

    // Positive saturation on the KI_SHIFT=0 instance, then strobe period shortens
    for (int i = 0; i < 70; i++) begin
      cyc(1, 1, 1, 1, 131071);
      cyc(1, 1, 0, 1, 0);
    end
    check("sat.pos_integ", integ1, 8388607);
    check("sat.pos_ctrl", ctrl1, 8388607);
    set_win(1, 1, 19, 20);
    for (int i = 0; i < 300; i++) cyc(1, 1, 0, 1, 0);
    check("sat.short", mn[1], 19);
    set_win(1, 0, 0, 0);

    // Negative saturation, strobe period lengthens
    for (int i = 0; i < 140; i++) begin
      cyc(1, 1, 1, 1, -131072);
      cyc(1, 1, 0, 1, 0);
    end
    check("sat.neg_integ", integ1, -8388607);
    check("sat.neg_ctrl", ctrl1, -8388607);
    set_win(1, 1, 20, 21);
    for (int i = 0; i < 300; i++) cyc(1, 1, 0, 1, 0);
    check("sat.long", mx[1], 21);
    set_win(1, 0, 0, 0);

    // Random iq_val gaps in free-run: strobes every 20 valid samples
    set_win(0, 1, 20, 20);
    set_win(1, 1, 20, 20);
    for (int i = 0; i < 600; i++) cyc(1, 1'($urandom_range(0, 1)), 0, 0, 0);
    check("gap.seen", mx[0], 20);
    set_win(0, 0, 0, 0);
    set_win(1, 0, 0, 0);

    // Reset mid-symbol at sample 13 with iq_val high: no strobe, sequence restarts
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++) cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    check("mid.sym_valid", sv0, 0);
    check("mid.mu", mu0, 0);
    for (int i = 0; i < 60; i++) begin
      cyc(1, 1, 0, 0, 0);
      if (sv0) check(nstrb[0] == 1 ? "mid.first" : "mid.period", ivl[0], 20);
    end

    // Build integ=500, then drop loop_en while the NCO keeps running
    for (int i = 0; i < 500; i++) cyc(1, 1, 1, 1, 4096);
    check("drop.integ_before", integ0, 500);
    cyc(1, 1, 0, 0, 0);
    check("drop.integ", integ0, 0);
    check("drop.ctrl", ctrl0, 0);
    for (int i = 0; i < 100; i++) cyc(1, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
